wb_bus_arbiter: RTL and testbench

Two-master to one-slave Wishbone classic arbiter that shares the single instruction/data memory port of the processor test wrapper. Master 0 is the CPU bus (cyc/stb/we/sel/addr/data). Master 1 is the controller's debug/load path. The block grants the slave port by round-robin, holds the grant for a whole cycle, and aborts hung transfers with a timeout error.

---
 rtl/wb_arb_pkg.sv | 21 ++
 rtl/wb_arb_timeout.sv | 40 ++++
 rtl/wb_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states, master index
// and the byte-select width helper.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    // 0 = CPU bus (m0), 1 = controller debug/load path (m1)
    typedef logic mst_idx_t;

    localparam mst_idx_t MST_M0 = 1'b0;
    localparam mst_idx_t MST_M1 = 1'b1;

    function automatic int sel_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall watchdog for the granted transfer: counts stb-without-ack cycles and
// flags the cycle in which the count hits TIMEOUT_CYCLES. Empty when disabled.
module wb_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_tmo;
            assign unused_tmo = ^{clk, rst_n, clear, inc};
            assign expired    = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear)    cnt_d = '0;
                else if (inc) cnt_d = cnt_q + 1'b1;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end

            // Fires on the stalled cycle that would bring the count to the limit.
            assign expired = inc && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master to one-slave Wishbone classic arbiter: round-robin grant held for
// a whole bus cycle, with timeout abort of hung transfers.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,

    input  logic                    m0_cyc,
    input  logic                    m0_stb,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH/8-1:0] m0_sel,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_data_out,
    output logic [DATA_WIDTH-1:0]   m0_data_in,
    output logic                    m0_ack,
    output logic                    m0_err,

    input  logic                    m1_cyc,
    input  logic                    m1_stb,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH/8-1:0] m1_sel,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_data_out,
    output logic [DATA_WIDTH-1:0]   m1_data_in,
    output logic                    m1_ack,
    output logic                    m1_err,

    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [DATA_WIDTH/8-1:0] s_sel,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_data_out,
    input  logic [DATA_WIDTH-1:0]   s_data_in,
    input  logic                    s_ack,

    output logic [1:0]              grant
);

    localparam int SW = sel_width(DATA_WIDTH);

    arb_state_e state_q, state_d;
    mst_idx_t   owner_q, owner_d;
    mst_idx_t   ptr_q, ptr_d;
    logic [1:0] grant_q, grant_d;

    logic       owner_cyc, owner_stb, owner_we;
    logic [SW-1:0]         owner_sel;
    logic [ADDR_WIDTH-1:0] owner_addr;
    logic [DATA_WIDTH-1:0] owner_data;
    logic       active, expired, tmo_clear, tmo_inc, ack_fwd;
    mst_idx_t   pick;

    assign owner_cyc  = (owner_q == MST_M1) ? m1_cyc      : m0_cyc;
    assign owner_stb  = (owner_q == MST_M1) ? m1_stb      : m0_stb;
    assign owner_we   = (owner_q == MST_M1) ? m1_we       : m0_we;
    assign owner_sel  = (owner_q == MST_M1) ? m1_sel      : m0_sel;
    assign owner_addr = (owner_q == MST_M1) ? m1_addr     : m0_addr;
    assign owner_data = (owner_q == MST_M1) ? m1_data_out : m0_data_out;

    // Bus is live only while granted and the owner still holds cyc.
    assign active    = (state_q == GRANT) && owner_cyc;
    assign tmo_inc   = active && owner_stb && !s_ack;
    assign tmo_clear = (state_q != GRANT) || s_ack || !owner_stb;

    wb_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .clear   (tmo_clear),
        .inc     (tmo_inc),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        pick    = MST_M0;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc || m1_cyc) begin
                    if (m0_cyc && m1_cyc) pick = ptr_q;
                    else                  pick = m1_cyc ? MST_M1 : MST_M0;
                    owner_d = pick;
                    state_d = GRANT;
                    grant_d = (pick == MST_M1) ? 2'b10 : 2'b01;
                end
            end
            GRANT, ABORT: begin
                if (!owner_cyc) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    ptr_d   = ~owner_q;
                end else if (state_q == GRANT && expired) begin
                    state_d = ABORT;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= MST_M0;
            ptr_q   <= MST_M0;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    assign grant = grant_q;

    // cyc/stb drop in the expiry cycle; the rest of the request stays visible.
    assign s_cyc      = active && !expired;
    assign s_stb      = active && !expired && owner_stb;
    assign s_we       = active && owner_we;
    assign s_sel      = active ? owner_sel  : '0;
    assign s_addr     = active ? owner_addr : '0;
    assign s_data_out = active ? owner_data : '0;

    assign ack_fwd = active && s_ack;
    assign m0_ack  = ack_fwd && (owner_q == MST_M0);
    assign m1_ack  = ack_fwd && (owner_q == MST_M1);
    assign m0_err  = expired && (owner_q == MST_M0);
    assign m1_err  = expired && (owner_q == MST_M1);

    // Read data is broadcast; held at zero while reset is asserted.
    assign m0_data_in = rst_n ? s_data_in : '0;
    assign m1_data_in = rst_n ? s_data_in : '0;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: read, round-robin, burst hold, timeout,
// ack/timeout race and async reset, with hand-computed expectations.
module tb_wb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          sys_clk = 1'b0;
    logic          rst_n;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [SW-1:0] m0_sel, m1_sel, s_sel;
    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic [DW-1:0] m0_data_out, m1_data_out, m0_data_in, m1_data_in;
    logic [DW-1:0] s_data_out, s_data_in;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we, s_ack;
    logic [1:0]    grant;

    int checks = 0;
    int passes = 0;

    wb_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
        .m0_addr(m0_addr), .m0_data_out(m0_data_out), .m0_data_in(m0_data_in),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_addr(m1_addr), .m1_data_out(m1_data_out), .m1_data_in(m1_data_in),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_addr(s_addr), .s_data_out(s_data_out), .s_data_in(s_data_in),
        .s_ack(s_ack), .grant(grant)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = '0; m0_addr = '0; m0_data_out = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = '0; m1_addr = '0; m1_data_out = '0;
        s_ack = 0; s_data_in = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        m0_cyc = 1; m0_stb = 1; s_ack = 1; s_data_in = 32'hAAAA_5555;
        tick();
        checks++; if (s_cyc !== 1'b0) $display("FAIL rst_scyc: got %b want 0", s_cyc); else passes++;
        checks++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant); else passes++;
        checks++; if (m0_ack !== 1'b0) $display("FAIL rst_m0ack: got %b want 0", m0_ack); else passes++;
        checks++; if (m0_data_in !== 32'h0) $display("FAIL rst_m0data: got %h want 0", m0_data_in); else passes++;
        idle_inputs();
        rst_n = 1;
        tick();
    endtask

    task automatic test_single_read();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'hF; m0_addr = 32'h100;
        #1;
        checks++; if (s_cyc !== 1'b0) $display("FAIL rd_latency: got s_cyc %b want 0", s_cyc); else passes++;
        tick();
        checks++; if (s_cyc !== 1'b1 || s_stb !== 1'b1) $display("FAIL rd_scyc: got %b%b want 11", s_cyc, s_stb); else passes++;
        checks++; if (s_addr !== 32'h100) $display("FAIL rd_addr: got %h want 100", s_addr); else passes++;
        checks++; if (grant !== 2'b01) $display("FAIL rd_grant: got %b want 01", grant); else passes++;
        checks++; if (m0_ack !== 1'b0) $display("FAIL rd_early_ack: got %b want 0", m0_ack); else passes++;
        tick();
        tick();
        s_ack = 1; s_data_in = 32'hDEAD_BEEF;
        #1;
        checks++; if (m0_ack !== 1'b1) $display("FAIL rd_ack: got %b want 1", m0_ack); else passes++;
        checks++; if (m0_data_in !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h want deadbeef", m0_data_in); else passes++;
        checks++; if (m1_ack !== 1'b0 || m0_err !== 1'b0) $display("FAIL rd_other: got m1_ack %b m0_err %b want 0 0", m1_ack, m0_err); else passes++;
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #1;
        checks++; if (s_cyc !== 1'b0 || m0_ack !== 1'b0) $display("FAIL rd_drop: got s_cyc %b m0_ack %b want 0 0", s_cyc, m0_ack); else passes++;
        tick();
        checks++; if (grant !== 2'b00) $display("FAIL rd_idle: got %b want 00", grant); else passes++;
    endtask

    task automatic test_simultaneous();
        rst_n = 0; #3; rst_n = 1;
        tick();
        m0_cyc = 1; m1_cyc = 1;
        tick();
        checks++; if (grant !== 2'b01) $display("FAIL rr_first: got %b want 01", grant); else passes++;
        m0_cyc = 0;
        #1;
        checks++; if (s_cyc !== 1'b0) $display("FAIL rr_drop_scyc: got %b want 0", s_cyc); else passes++;
        tick();
        checks++; if (grant !== 2'b00) $display("FAIL rr_gap: got %b want 00", grant); else passes++;
        tick();
        checks++; if (grant !== 2'b10 || s_cyc !== 1'b1) $display("FAIL rr_second: got grant %b s_cyc %b want 10 1", grant, s_cyc); else passes++;
        m1_cyc = 0;
        tick();
        m0_cyc = 1; m1_cyc = 1;
        tick();
        checks++; if (grant !== 2'b01) $display("FAIL rr_alternate: got %b want 01", grant); else passes++;
        m0_cyc = 0; m1_cyc = 0;
        tick();
        tick();
    endtask

    task automatic test_burst_hold();
        // m0 was served last, so m1 wins the simultaneous request
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF; m1_addr = '0; m1_data_out = 32'd1;
        m0_cyc = 1; m0_stb = 1;
        tick();
        checks++; if (grant !== 2'b10) $display("FAIL burst_grant: got %b want 10", grant); else passes++;
        for (int i = 0; i < 4; i++) begin
            m1_addr = 32'(4 * i); m1_data_out = 32'(i + 1); s_ack = 1;
            #1;
            checks++; if (s_addr !== 32'(4 * i)) $display("FAIL burst_addr%0d: got %h want %h", i, s_addr, 4 * i); else passes++;
            checks++; if (s_data_out !== 32'(i + 1)) $display("FAIL burst_data%0d: got %h want %h", i, s_data_out, i + 1); else passes++;
            checks++; if (s_we !== 1'b1 || grant !== 2'b10) $display("FAIL burst_hold%0d: got we %b grant %b want 1 10", i, s_we, grant); else passes++;
            checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) $display("FAIL burst_ack%0d: got m1 %b m0 %b want 1 0", i, m1_ack, m0_ack); else passes++;
            tick();
        end
        s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
        #1;
        checks++; if (s_cyc !== 1'b0 || grant !== 2'b10) $display("FAIL burst_end: got s_cyc %b grant %b want 0 10", s_cyc, grant); else passes++;
        tick();
        checks++; if (grant !== 2'b00) $display("FAIL burst_gap: got %b want 00", grant); else passes++;
        tick();
        checks++; if (grant !== 2'b01 || s_we !== 1'b0) $display("FAIL burst_m0: got grant %b we %b want 01 0", grant, s_we); else passes++;
        m0_cyc = 0; m0_stb = 0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        m0_cyc = 1; m0_stb = 1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            if (k < 8) begin
                checks++; if (m0_err !== 1'b0 || s_cyc !== 1'b1) $display("FAIL tmo_cycle%0d: got err %b s_cyc %b want 0 1", k, m0_err, s_cyc); else passes++;
            end else begin
                checks++; if (m0_err !== 1'b1) $display("FAIL tmo_err: got %b want 1", m0_err); else passes++;
                checks++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) $display("FAIL tmo_force: got %b%b want 00", s_cyc, s_stb); else passes++;
            end
            tick();
        end
        checks++; if (m0_err !== 1'b0 || s_cyc !== 1'b0) $display("FAIL tmo_abort: got err %b s_cyc %b want 0 0", m0_err, s_cyc); else passes++;
        checks++; if (grant !== 2'b01) $display("FAIL tmo_grant: got %b want 01", grant); else passes++;
        tick();
        checks++; if (s_cyc !== 1'b0 || m0_err !== 1'b0) $display("FAIL tmo_abort2: got s_cyc %b err %b want 0 0", s_cyc, m0_err); else passes++;
        m0_cyc = 0; m0_stb = 0;
        tick();
        checks++; if (grant !== 2'b00) $display("FAIL tmo_release: got %b want 00", grant); else passes++;
    endtask

    task automatic test_race();
        m0_cyc = 1; m0_stb = 1;
        tick();
        repeat (7) tick();
        s_ack = 1; s_data_in = 32'h1234_5678;
        #1;
        checks++; if (m0_ack !== 1'b1 || m0_err !== 1'b0) $display("FAIL race_ack: got ack %b err %b want 1 0", m0_ack, m0_err); else passes++;
        checks++; if (s_cyc !== 1'b1) $display("FAIL race_scyc: got %b want 1", s_cyc); else passes++;
        tick();
        s_ack = 0;
        #1;
        checks++; if (m0_err !== 1'b0 || s_cyc !== 1'b1 || grant !== 2'b01) $display("FAIL race_continue: got err %b s_cyc %b grant %b want 0 1 01", m0_err, s_cyc, grant); else passes++;
        m0_cyc = 0; m0_stb = 0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        m0_cyc = 1; m0_stb = 1;
        tick();
        s_ack = 1;
        #1;
        checks++; if (m0_ack !== 1'b1 || grant !== 2'b01) $display("FAIL arst_pre: got ack %b grant %b want 1 01", m0_ack, grant); else passes++;
        #2;
        rst_n = 0;
        #1;
        checks++; if (s_cyc !== 1'b0 || grant !== 2'b00) $display("FAIL arst_bus: got s_cyc %b grant %b want 0 00", s_cyc, grant); else passes++;
        checks++; if (m0_ack !== 1'b0 || m0_err !== 1'b0 || m1_ack !== 1'b0) $display("FAIL arst_ack: got %b%b%b want 000", m0_ack, m0_err, m1_ack); else passes++;
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #3;
        rst_n = 1;
        tick();
        m0_cyc = 1; m1_cyc = 1;
        tick();
        checks++; if (grant !== 2'b01) $display("FAIL arst_prio: got %b want 01", grant); else passes++;
        m0_cyc = 0; m1_cyc = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_burst_hold();
        test_timeout();
        test_race();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
